// File: rtl/niosduino_onchip_memory_dp.sv
// -----------------------------------------------------------------------------
// niosduino_onchip_memory_dp
//   True-dual-port on-chip RAM with two independent Avalon-MM slave ports.
//   s1 is intended for CPU instruction/data traffic, s2 for DMA or tensor
//   buffer access. Both ports share one memory array, split into byte lanes.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   clken, reset_req    block enable is clken & ~reset_req; when it is low the
//                       block is frozen and requests are dropped
//   s1_* / s2_*         address, byteenable, chipselect, read, write,
//                       writedata in; readdata, readdatavalid out
//
// Read latency is 1 + OUTPUT_REG enabled cycles. readdatavalid pulses once
// per accepted read.
//
// INIT_FILE is accepted for compatibility with the system integration flow.
// This RTL does not load it, so memory contents start undefined.
// -----------------------------------------------------------------------------
module niosduino_onchip_memory_dp #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 8192,
  parameter int    ADDR_WIDTH = 13,
  parameter int    OUTPUT_REG = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int          NUM_LANES = DATA_WIDTH / 8;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);

  logic w_en;
  assign w_en = clken & ~reset_req;

  // Port signals are packed into two-entry arrays so that both ports share
  // one generate body. Index 0 is s1 and index 1 is s2.
  logic [ADDR_WIDTH-1:0]   w_addr    [2];
  logic [NUM_LANES-1:0]    w_be      [2];
  logic [DATA_WIDTH-1:0]   w_wdata   [2];
  logic [1:0]              w_inrange;
  logic [1:0]              w_wr;
  logic [1:0]              w_rd;
  logic [1:0][DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0]   w_rdata   [2];
  logic [1:0]              w_rvalid;

  assign w_addr[0]  = s1_address;
  assign w_addr[1]  = s2_address;
  assign w_be[0]    = s1_byteenable;
  assign w_be[1]    = s2_byteenable;
  assign w_wdata[0] = s1_writedata;
  assign w_wdata[1] = s2_writedata;

  // A write always takes priority over a read on the same port. Out-of-range
  // writes are suppressed. Out-of-range reads are still issued and return 0.
  assign w_inrange[0] = (32'(s1_address) < DEPTH_U);
  assign w_inrange[1] = (32'(s2_address) < DEPTH_U);
  assign w_wr[0] = s1_chipselect & s1_write & w_en & w_inrange[0];
  assign w_wr[1] = s2_chipselect & s2_write & w_en & w_inrange[1];
  assign w_rd[0] = s1_chipselect & s1_read & ~s1_write & w_en;
  assign w_rd[1] = s2_chipselect & s2_read & ~s2_write & w_en;

  // One memory array per byte lane, so each lane has a single write process.
  // s2 is written first and s1 last, so s1 wins on a shared lane when both
  // ports write the same address. Reads sample the array before the edge
  // updates it, so a cross-port collision returns the old data.
  genvar gi, gp;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (w_wr[1] && w_be[1][gi]) begin
          r_mem[w_addr[1]] <= w_wdata[1][gi*8 +: 8];
        end
        if (w_wr[0] && w_be[0][gi]) begin
          r_mem[w_addr[0]] <= w_wdata[0][gi*8 +: 8];
        end
      end

      for (gp = 0; gp < 2; gp++) begin : g_rd
        assign w_mem_rd[gp][gi*8 +: 8] = r_mem[w_addr[gp]];
      end
    end

    for (gp = 0; gp < 2; gp++) begin : g_port
      logic [DATA_WIDTH-1:0] r_q1;
      logic                  r_v1;

      // The first stage loads only on an accepted read. Its valid bit is a
      // one-cycle pulse per read and holds while the block is stalled.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_q1 <= '0;
          r_v1 <= 1'b0;
        end else if (w_en) begin
          r_v1 <= w_rd[gp];
          if (w_rd[gp]) begin
            r_q1 <= w_inrange[gp] ? w_mem_rd[gp] : '0;
          end
        end
      end

      if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_q2;
        logic                  r_v2;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_q2 <= '0;
            r_v2 <= 1'b0;
          end else if (w_en) begin
            r_q2 <= r_q1;
            r_v2 <= r_v1;
          end
        end

        assign w_rdata[gp]  = r_q2;
        assign w_rvalid[gp] = r_v2;
      end else begin : g_noreg
        assign w_rdata[gp]  = r_q1;
        assign w_rvalid[gp] = r_v1;
      end
    end
  endgenerate

  assign s1_readdata      = w_rdata[0];
  assign s1_readdatavalid = w_rvalid[0];
  assign s2_readdata      = w_rdata[1];
  assign s2_readdatavalid = w_rvalid[1];

endmodule
